// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-engine state encoding and default baud constants
// (12 MHz system clock, 115200 baud).
package uart_pkg;

    localparam int unsigned UART_CLK_HZ       = 12_000_000;
    localparam int unsigned UART_BAUD         = 115_200;
    localparam int unsigned UART_CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD;
    localparam int unsigned UART_TIMEOUT_BITS = 20;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_8n1_core.sv
// 8N1 UART deserializer: two-flop synchroniser, bit engine, byte strobe and
// frame-error pulse (both one cycle, registered).
module uart_rx_8n1_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd_i,
    output logic [7:0] byte_o,
    output logic       byte_stb_o,
    output logic       frame_err_o
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_param_chk
        $error("uart_rx_8n1_core: CLKS_PER_BIT must be at least 2");
    end

    logic            rx_meta_q, rx_sync_q;
    logic [1:0]      warm_q;
    logic            hi_seen_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            stb_q, stb_d;
    logic            ferr_q, ferr_d;

    // hi_seen_q only trusts samples that travelled the whole synchroniser, so a
    // line held low across reset release never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            warm_q    <= 2'b00;
            hi_seen_q <= 1'b0;
        end else begin
            rx_meta_q <= rxd_i;
            rx_sync_q <= rx_meta_q;
            warm_q    <= {warm_q[0], 1'b1};
            hi_seen_q <= warm_q[1] & rx_sync_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        stb_d   = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (hi_seen_q && !rx_sync_q) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!rx_sync_q) begin
                        state_d = RX_DATA;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shreg_d = {rx_sync_q, shreg_q[7:1]};
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_sync_q) stb_d  = 1'b1;
                    else           ferr_d = 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            stb_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            stb_q   <= stb_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_o      = shreg_q;
    assign byte_stb_o  = stb_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/packet_receiver.sv
// UART packet receiver: assembles PACKET_BYTES bytes (first byte = LSB) into a
// valid/ready output slot. Optional inter-byte timeout: PACKET_RECEIVER_TIMEOUT_EN.
module packet_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned PACKET_BYTES = 2,
    parameter int unsigned TIMEOUT_CLKS = UART_TIMEOUT_BITS * CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rxd,
    output logic [8*PACKET_BYTES-1:0] pkt_data,
    output logic                      pkt_valid,
    input  logic                      pkt_ready,
    output logic                      frame_err,
    output logic                      overrun,
    output logic                      timeout_err,
    output logic                      busy
);

    localparam int unsigned PW = 8 * PACKET_BYTES;
    localparam int unsigned CW = $clog2(PACKET_BYTES + 1);
    localparam logic [CW-1:0] LAST = CW'(PACKET_BYTES - 1);

    if (PACKET_BYTES < 1 || PACKET_BYTES > 8 || TIMEOUT_CLKS < 1) begin : g_param_chk
        $error("packet_receiver: PACKET_BYTES must be 1..8 and TIMEOUT_CLKS >= 1");
    end

    logic [7:0]    rx_byte;
    logic          rx_stb;
    logic          rx_ferr;

    logic [CW-1:0] bcnt_q, bcnt_d;
    logic [PW-1:0] asm_q, asm_d;
    logic [PW-1:0] data_q, data_d;
    logic          vld_q, vld_d;
    logic          ovr_q, ovr_d;
    logic          ferr_q;
    logic          tmo_q;
    logic          tmo_fire;

    uart_rx_8n1_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxd_i       (rxd),
        .byte_o      (rx_byte),
        .byte_stb_o  (rx_stb),
        .frame_err_o (rx_ferr)
    );

`ifdef PACKET_RECEIVER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
    logic [TW-1:0] tcnt_q;

    // Gap counter restarts on every byte; a strobe in the firing cycle wins.
    assign tmo_fire = (bcnt_q != '0) && (tcnt_q == TW'(TIMEOUT_CLKS - 1)) && !rx_stb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    tcnt_q <= '0;
        else if (rx_stb || bcnt_q == '0 || tmo_fire)   tcnt_q <= '0;
        else                                           tcnt_q <= tcnt_q + 1'b1;
    end
`else
    assign tmo_fire = 1'b0;
`endif

    always_comb begin
        bcnt_d = bcnt_q;
        asm_d  = asm_q;
        data_d = data_q;
        vld_d  = vld_q;
        ovr_d  = 1'b0;
        if (vld_q && pkt_ready) vld_d = 1'b0;
        if (rx_ferr) begin
            bcnt_d = '0;
        end else if (rx_stb) begin
            for (int k = 0; k < PACKET_BYTES; k++) begin
                if (bcnt_q == CW'(k)) asm_d[8*k +: 8] = rx_byte;
            end
            if (bcnt_q == LAST) begin
                bcnt_d = '0;
                // A same-cycle handshake frees the slot for the new packet.
                if (!vld_q || pkt_ready) begin
                    data_d = asm_d;
                    vld_d  = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end else if (tmo_fire) begin
            bcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q <= '0;
            asm_q  <= '0;
            data_q <= '0;
            vld_q  <= 1'b0;
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            bcnt_q <= bcnt_d;
            asm_q  <= asm_d;
            data_q <= data_d;
            vld_q  <= vld_d;
            ovr_q  <= ovr_d;
            ferr_q <= rx_ferr;
            tmo_q  <= tmo_fire;
        end
    end

    assign pkt_data    = data_q;
    assign pkt_valid   = vld_q;
    assign overrun     = ovr_q;
    assign frame_err   = ferr_q;
    assign timeout_err = tmo_q;
    assign busy        = (bcnt_q != '0);

endmodule

// File: tb/tb_packet_receiver.sv
// Directed bench for packet_receiver with CLKS_PER_BIT=4, PACKET_BYTES=2.
module tb_packet_receiver;

    localparam int CPB = 4;
    localparam int PB  = 2;
    localparam int TMO = 80;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rxd = 1'b1;
    logic          pkt_ready = 1'b0;
    logic [15:0]   pkt_data;
    logic          pkt_valid, frame_err, overrun, timeout_err, busy;

    int checks = 0;
    int errors = 0;
    int n_ferr = 0, n_ovr = 0, n_tmo = 0;
    int f0, o0, t0;
    logic hit;

    always #5 clk = ~clk;

    packet_receiver #(
        .CLKS_PER_BIT(CPB),
        .PACKET_BYTES(PB),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxd         (rxd),
        .pkt_data    (pkt_data),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always @(negedge clk) begin
        if (frame_err)   n_ferr <= n_ferr + 1;
        if (overrun)     n_ovr  <= n_ovr + 1;
        if (timeout_err) n_tmo  <= n_tmo + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        tick(1);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = stop;
        tick(CPB);
        rxd = 1'b1;
        tick(3 * CPB);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 400 && !pkt_valid; i++) @(negedge clk);
        @(negedge clk);
        check(tag, pkt_valid, 1'b1);
    endtask

    task automatic consume();
        @(negedge clk);
        pkt_ready = 1'b1;
        @(posedge clk);
        #1 pkt_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        tick(3);
        @(negedge clk);
        check("rst_data",  pkt_data, 16'h0000);
        check("rst_valid", pkt_valid, 1'b0);
        check("rst_busy",  busy, 1'b0);
        check("rst_ferr",  frame_err, 1'b0);
        check("rst_ovr",   overrun, 1'b0);
        check("rst_tmo",   timeout_err, 1'b0);
        rst_n = 1'b1;
        tick(5);

        // basic packet
        f0 = n_ferr; o0 = n_ovr; t0 = n_tmo;
        send_byte(8'h34, 1'b1);
        @(negedge clk);
        check("basic_busy", busy, 1'b1);
        send_byte(8'h12, 1'b1);
        wait_valid("basic_valid");
        check("basic_data", pkt_data, 16'h1234);
        check("basic_idle", busy, 1'b0);
        tick(10);
        @(negedge clk);
        check("basic_hold_v", pkt_valid, 1'b1);
        check("basic_hold_d", pkt_data, 16'h1234);
        consume();
        @(negedge clk);
        check("basic_drop", pkt_valid, 1'b0);
        check("basic_noferr", n_ferr - f0, 0);
        check("basic_noovr",  n_ovr - o0, 0);
        check("basic_notmo",  n_tmo - t0, 0);

        // overrun: second packet dropped
        o0 = n_ovr;
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        wait_valid("ovr_valid");
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        @(negedge clk);
        check("ovr_data",  pkt_data, 16'h1234);
        check("ovr_valid2", pkt_valid, 1'b1);
        check("ovr_count", n_ovr - o0, 1);
        consume();

        // handshake in the completion cycle
        o0 = n_ovr;
        hit = 1'b0;
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        wait_valid("sim_valid");
        send_byte(8'hEF, 1'b1);
        fork
            send_byte(8'hBE, 1'b1);
            begin
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (dut.u_core.byte_stb_o) begin
                        pkt_ready = 1'b1;
                        hit = 1'b1;
                        @(posedge clk);
                        #1 pkt_ready = 1'b0;
                        break;
                    end
                end
            end
        join
        @(negedge clk);
        check("sim_hit",   hit, 1'b1);
        check("sim_data",  pkt_data, 16'hBEEF);
        check("sim_valid2", pkt_valid, 1'b1);
        check("sim_noovr", n_ovr - o0, 0);
        consume();

        // frame error discards partial packet
        f0 = n_ferr;
        send_byte(8'h34, 1'b1);
        send_byte(8'h55, 1'b0);
        @(negedge clk);
        check("ferr_count", n_ferr - f0, 1);
        check("ferr_busy",  busy, 1'b0);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        wait_valid("ferr_valid");
        check("ferr_data", pkt_data, 16'h1234);
        consume();

        // inter-byte silence
        t0 = n_tmo;
        send_byte(8'h34, 1'b1);
        @(negedge clk);
        check("tmo_busy0", busy, 1'b1);
        tick(TMO + 20);
        @(negedge clk);
`ifdef PACKET_RECEIVER_TIMEOUT_EN
        check("tmo_count", n_tmo - t0, 1);
        check("tmo_busy",  busy, 1'b0);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        wait_valid("tmo_valid");
        check("tmo_data", pkt_data, 16'h5678);
`else
        check("tmo_count", n_tmo - t0, 0);
        check("tmo_busy",  busy, 1'b1);
        send_byte(8'h12, 1'b1);
        wait_valid("tmo_valid");
        check("tmo_data", pkt_data, 16'h1234);
`endif
        consume();

        // reset during data bit 4, with a pending packet and a partial one
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        wait_valid("rmf_valid0");
        send_byte(8'h78, 1'b1);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = (i == 2) ? 1'b1 : 1'b0;
            tick(CPB);
        end
        rxd = 1'b1;
        tick(2);
        rst_n = 1'b0;
        tick(2);
        @(negedge clk);
        check("rmf_valid", pkt_valid, 1'b0);
        check("rmf_data",  pkt_data, 16'h0000);
        check("rmf_busy",  busy, 1'b0);
        rst_n = 1'b1;
        tick(15 * CPB);
        @(negedge clk);
        check("rmf_nostb_busy",  busy, 1'b0);
        check("rmf_nostb_valid", pkt_valid, 1'b0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h5A, 1'b1);
        wait_valid("rmf_valid2");
        check("rmf_data2", pkt_data, 16'h5AA5);
        consume();

        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
